ram_burst_reader: RTL and testbench

Read-side sequencer for the team's single-port-read `ramdata` style buffers (LSTM weights, hidden state, gate results). On a start request it walks a contiguous, wrapping address range in the RAM, compensates for the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream with backpressure and a last-word flag. It sits between a RAM instance's read port and the LSTM datapath (MAC array / activation units).

---
 rtl/ram_rd_pkg.sv | 14 +
 rtl/ram_burst_reader_if.sv | 32 +++
 rtl/ram_rd_skid_fifo.sv | 65 ++++++
 rtl/ram_burst_reader.sv | 105 ++++++++++
 tb/tb_ram_burst_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM burst reader and its output FIFO.
package ram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM read-port and output-stream signals of one burst reader.
interface ram_burst_reader_if #(
    parameter int addr_width = 4,
    parameter int data_width = 8
);
    logic                  start;
    logic [addr_width-1:0] base_addr;
    logic [addr_width:0]   len;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  ram_cs;
    logic                  ram_rd_en;
    logic [addr_width-1:0] ram_rd_addr;
    logic [data_width-1:0] ram_rd_data;
    logic                  m_valid;
    logic [data_width-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    // The reader itself: drives the RAM port and the stream.
    modport master (
        input  start, base_addr, len, abort, ram_rd_data, m_ready,
        output busy, done, ram_cs, ram_rd_en, ram_rd_addr, m_valid, m_data, m_last
    );

    // The environment: controller, RAM and downstream consumer.
    modport slave (
        output start, base_addr, len, abort, ram_rd_data, m_ready,
        input  busy, done, ram_cs, ram_rd_en, ram_rd_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry synchronous FIFO holding RAM words plus their last-word flag.
module ram_rd_skid_fifo
    import ram_rd_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [data_width-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_pop,
    output logic                  o_empty,
    output logic [data_width-1:0] o_data,
    output logic                  o_last,
    output logic [FIFO_CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [data_width-1:0] r_data [FIFO_DEPTH];
    logic                  r_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) || w_pop);

    // NOTE: storage is reset here on purpose: the head word is a module output and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_data[i] <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= i_data;
                r_last[r_wr_ptr] <= i_last;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + FIFO_CNT_W'(w_push) - FIFO_CNT_W'(w_pop);
        end
    end

    assign o_empty = (r_count == '0);
    assign o_data  = r_data[r_rd_ptr];
    assign o_last  = r_last[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ram_burst_reader.sv
// Walks a wrapping address range of a registered-read RAM and streams the
// words out as valid/ready with a last flag, hiding the one-cycle read latency.
module ram_burst_reader #(
    parameter int addr_width  = 4,
    parameter int data_width  = 8,
    parameter int data_deepth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_burst_reader_if.master  bus
);
    import ram_rd_pkg::*;

    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(data_deepth - 1);
    localparam int                    OCC_W     = FIFO_CNT_W + 1;

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [addr_width-1:0] r_addr;
    logic [addr_width:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;

    logic                  w_abort;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_last_issue;
    logic [OCC_W-1:0]      w_occupancy;
    logic                  w_fifo_empty;
    logic                  w_fifo_last;
    logic [data_width-1:0] w_fifo_data;
    logic [FIFO_CNT_W-1:0] w_fifo_count;

    assign w_abort = bus.abort && (r_state != IDLE);
    assign w_pop   = !w_fifo_empty && bus.m_ready;

    // Slots that stay claimed after this edge: words held plus the word landing, minus the one leaving.
    assign w_occupancy  = {1'b0, w_fifo_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_issue      = (r_state == READ) && !w_abort && (w_occupancy < OCC_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_remaining == (addr_width+1)'(1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = (bus.len == '0) ? DONE : READ;
            READ:    if (w_last_issue) w_state_nxt = DRAIN;
            DRAIN:   if (w_fifo_empty && !r_inflight) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            if (r_state == IDLE && bus.start) begin
                r_addr      <= bus.base_addr;
                r_remaining <= bus.len;
            end else if (w_issue) begin
                r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    // Abort flushes the FIFO and, since flush beats push, drops the word in flight.
    ram_rd_skid_fifo #(
        .data_width (data_width)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_abort),
        .i_push  (r_inflight),
        .i_data  (bus.ram_rd_data),
        .i_last  (r_inflight_last),
        .i_pop   (w_pop),
        .o_empty (w_fifo_empty),
        .o_data  (w_fifo_data),
        .o_last  (w_fifo_last),
        .o_count (w_fifo_count)
    );

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.ram_rd_en   = w_issue;
    assign bus.ram_cs      = w_issue;
    assign bus.ram_rd_addr = r_addr;
    assign bus.m_valid     = !w_fifo_empty;
    assign bus.m_data      = w_fifo_data;
    assign bus.m_last      = w_fifo_last;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a registered-read RAM model feeds the
// DUT, expected addresses and words are queued at start and checked on use.
module tb_ram_burst_reader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ram_burst_reader_if #(.addr_width(AW), .data_width(DW)) bus ();

    ram_burst_reader #(
        .addr_width  (AW),
        .data_width  (DW),
        .data_deepth (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    int n_vec     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    int valid_cnt = 0;
    int rd_cnt    = 0;
    int acc_cnt   = 0;

    logic [DW:0]   exp_q  [$];
    logic [AW-1:0] addr_q [$];
    logic [DW:0]   exp_word;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ram_word(input int a);
        return DW'(a * 37 + 11);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, handshakes complete on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_rd_en) begin
                rd_cnt++;
                check("ram_cs", bus.ram_cs, 1);
                if (addr_q.size() > 0) check("rd_addr", bus.ram_rd_addr, addr_q.pop_front());
                else                   check("rd_unexpected", bus.ram_rd_en, 0);
            end else if (bus.ram_cs) begin
                check("ram_cs_idle", bus.ram_cs, 0);
            end
            if (bus.m_valid) valid_cnt++;
            if (bus.m_valid && bus.m_ready) begin
                acc_cnt++;
                if (exp_q.size() > 0) begin
                    exp_word = exp_q.pop_front();
                    check("m_data", bus.m_data, exp_word[DW-1:0]);
                    check("m_last", bus.m_last, exp_word[DW]);
                end else begin
                    check("word_unexpected", bus.m_valid, 0);
                end
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic start_burst(input int base, input int n);
        bus.base_addr = AW'(base);
        bus.len       = (AW+1)'(n);
        bus.start     = 1'b1;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % DEPTH;
            addr_q.push_back(AW'(a));
            exp_q.push_back({(i == n - 1), ram_word(a)});
        end
        tick();
        start_cyc     = cyc;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.len       = (AW+1)'($urandom_range(0, DEPTH));
    endtask

    task automatic wait_done(input int exp_cyc, input bit toggle);
        bit found;
        int d0;
        found = 1'b0;
        d0    = done_cnt;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                if (exp_cyc >= 0) check("done_cycle", cyc, exp_cyc);
            end else if (toggle) begin
                @(posedge clk);
                #1;
                bus.m_ready = ~bus.m_ready;
            end
        end
        check("done_seen", found, 1);
        @(negedge clk);
        check("busy_after_done", bus.busy, 0);
        check("done_one_cycle", bus.done, 0);
        check("done_count", done_cnt - d0, 1);
        check("words_pending", exp_q.size(), 0);
        check("reads_pending", addr_q.size(), 0);
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_busy"},    bus.busy, 0);
        check({phase, "_done"},    bus.done, 0);
        check({phase, "_ram_cs"},  bus.ram_cs, 0);
        check({phase, "_rd_en"},   bus.ram_rd_en, 0);
        check({phase, "_rd_addr"}, bus.ram_rd_addr, 0);
        check({phase, "_m_valid"}, bus.m_valid, 0);
        check({phase, "_m_data"},  bus.m_data, 0);
        check({phase, "_m_last"},  bus.m_last, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, r0, d0, a0;
        for (int i = 0; i < DEPTH; i++) mem[i] = ram_word(i);
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.m_ready   = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;

        #23;
        check_all_zero("reset");
        #4 rst_n = 1'b1;
        tick();

        // base 3, len 5, consumer always ready
        bus.m_ready = 1'b1;
        start_burst(3, 5);
        @(negedge clk);
        check("first_rd_en", bus.ram_rd_en, 1);
        check("first_rd_addr", bus.ram_rd_addr, 3);
        @(negedge clk);
        check("valid_after_e1", bus.m_valid, 0);
        @(negedge clk);
        check("valid_after_e2", bus.m_valid, 1);
        wait_done(start_cyc + 8, 1'b0);

        // address wrap 14,15,0,1, started in the first idle cycle
        start_burst(14, 4);
        wait_done(start_cyc + 7, 1'b0);

        // backpressure toggling, plus a start while busy that must be ignored
        r0 = rd_cnt;
        start_burst(2, 6);
        bus.m_ready = 1'b0;
        tick();
        bus.m_ready   = 1'b1;
        bus.start     = 1'b1;
        bus.base_addr = 4'd0;
        bus.len       = 5'd3;
        tick();
        bus.start   = 1'b0;
        bus.m_ready = 1'b0;
        wait_done(-1, 1'b1);
        check("toggle_reads", rd_cnt - r0, 6);

        // zero-length burst
        bus.m_ready = 1'b1;
        v0 = valid_cnt;
        r0 = rd_cnt;
        start_burst(7, 0);
        wait_done(start_cyc, 1'b0);
        check("len0_valid", valid_cnt - v0, 0);
        check("len0_reads", rd_cnt - r0, 0);

        // abort after two words accepted
        d0 = done_cnt;
        a0 = acc_cnt;
        start_burst(9, 8);
        for (int i = 0; i < 50 && (acc_cnt - a0) < 2; i++) @(negedge clk);
        check("abort_setup", acc_cnt - a0, 2);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        bus.abort   = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_q.delete();
        addr_q.delete();
        check("abort_busy", bus.busy, 0);
        check("abort_m_valid", bus.m_valid, 0);
        check("abort_rd_en", bus.ram_rd_en, 0);
        repeat (6) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_valid", bus.m_valid, 0);
        bus.m_ready = 1'b1;
        start_burst(0, 2);
        wait_done(start_cyc + 5, 1'b0);

        // asynchronous reset mid-burst, then a clean burst
        start_burst(5, 8);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        addr_q.delete();
        #3 rst_n = 1'b1;
        tick();
        start_burst(12, 3);
        wait_done(start_cyc + 6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
